// File: rtl/safe_lock_ctrl_param.sv
// Parametrised safe lock controller: keypad code entry, programming, timed messages and lockout.
// Optional master-code unlock is enabled by defining SAFE_MASTER_CODE_EN.
module safe_lock_ctrl_param #(
  parameter int unsigned CODE_LEN = 4,
  parameter int unsigned MSG_TICKS = 10,
  parameter int unsigned MAX_FAILS = 3,
  parameter int unsigned LOCKOUT_TICKS = 50,
  parameter logic [4*CODE_LEN-1:0] MASTER_CODE = {CODE_LEN{4'h0}}
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [11:0]                        key,
  output logic                               lock,
  output logic [2:0]                         state_o,
  output logic [$clog2(CODE_LEN+1)-1:0]      entry_cnt,
  output logic [4*CODE_LEN-1:0]              entry_digits,
  output logic [$clog2(MAX_FAILS+1)-1:0]     fail_cnt
);

  localparam int unsigned CW   = $clog2(CODE_LEN + 1);
  localparam int unsigned FW   = $clog2(MAX_FAILS + 1);
  localparam int unsigned DW   = 4 * CODE_LEN;
  localparam int unsigned TMAX = (MSG_TICKS > LOCKOUT_TICKS) ? MSG_TICKS : LOCKOUT_TICKS;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

`ifdef SAFE_MASTER_CODE_EN
  localparam bit USE_MASTER = 1'b1;
`else
  localparam bit USE_MASTER = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_UNSET    = 3'd0,
    S_LOCKED   = 3'd1,
    S_SUCCESS  = 3'd2,
    S_ERROR    = 3'd3,
    S_LOCKOUT  = 3'd4,
    S_UNLOCKED = 3'd5
  } state_t;

  state_t         state_q, state_d;
  logic           lock_q, lock_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]  digits_q, digits_d;
  logic [FW-1:0]  fail_q, fail_d;
  logic [DW-1:0]  code_q, code_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [11:0]    key_prev_q, key_prev_d;

  logic           press, is_digit, is_clear, complete, entry_ok, match;
  logic [3:0]     digit;
  logic [DW-1:0]  ins;

  // Press decode and entry buffer with the incoming digit placed at slot cnt_q
  always_comb begin
    press    = $onehot(key) && (key_prev_q == 12'd0);
    is_digit = press && (key[9:0] != 10'd0);
    is_clear = press && key[10];
    digit    = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (key[i]) digit = 4'(i);
    end
    ins = digits_q;
    for (int s = 0; s < int'(CODE_LEN); s++) begin
      if (CW'(s) == cnt_q) ins[DW-1-4*s -: 4] = digit;
    end
    complete = is_digit && (cnt_q == CW'(CODE_LEN - 1));
    match    = (ins == code_q) || (USE_MASTER && (ins == MASTER_CODE));
    entry_ok = (state_q == S_UNSET) || (state_q == S_LOCKED) || (state_q == S_UNLOCKED);
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    digits_d   = digits_q;
    fail_d     = fail_q;
    code_d     = code_q;
    timer_d    = timer_q;
    key_prev_d = key;

    if (entry_ok) begin
      if (is_clear || complete) begin
        cnt_d    = '0;
        digits_d = '1;
      end else if (is_digit) begin
        cnt_d    = cnt_q + CW'(1);
        digits_d = ins;
      end
    end

    case (state_q)
      S_UNSET, S_UNLOCKED: begin
        if (complete) begin
          code_d  = ins;
          state_d = S_LOCKED;
        end
      end
      S_LOCKED: begin
        if (complete) begin
          timer_d = '0;
          if (match) begin
            state_d = S_SUCCESS;
            fail_d  = '0;
          end else begin
            fail_d  = fail_q + FW'(1);
            state_d = ((fail_q + FW'(1)) == FW'(MAX_FAILS)) ? S_LOCKOUT : S_ERROR;
          end
        end
      end
      S_SUCCESS: begin
        if (timer_q == TW'(MSG_TICKS - 1)) state_d = S_UNLOCKED;
        else timer_d = timer_q + TW'(1);
      end
      S_ERROR: begin
        if (timer_q == TW'(MSG_TICKS - 1)) state_d = S_LOCKED;
        else timer_d = timer_q + TW'(1);
      end
      S_LOCKOUT: begin
        if (timer_q == TW'(LOCKOUT_TICKS - 1)) begin
          state_d = S_LOCKED;
          fail_d  = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = S_UNSET;
    endcase

    lock_d = (state_d != S_UNSET) && (state_d != S_UNLOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_UNSET;
      lock_q     <= 1'b0;
      cnt_q      <= '0;
      digits_q   <= '1;
      fail_q     <= '0;
      code_q     <= '0;
      timer_q    <= '0;
      key_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_q     <= lock_d;
      cnt_q      <= cnt_d;
      digits_q   <= digits_d;
      fail_q     <= fail_d;
      code_q     <= code_d;
      timer_q    <= timer_d;
      key_prev_q <= key_prev_d;
    end
  end

  assign lock         = lock_q;
  assign state_o      = state_q;
  assign entry_cnt    = cnt_q;
  assign entry_digits = digits_q;
  assign fail_cnt     = fail_q;

endmodule

// File: tb/tb_safe_lock_ctrl_param.sv
// Scoreboard bench for safe_lock_ctrl_param: queue-based reference model, per-cycle snapshot compare.
module tb_safe_lock_ctrl_param;

  localparam int CODE_LEN      = 4;
  localparam int MSG_TICKS     = 10;
  localparam int MAX_FAILS     = 3;
  localparam int LOCKOUT_TICKS = 50;
  localparam logic [4*CODE_LEN-1:0] TB_MASTER = {CODE_LEN{4'h0}};

`ifdef SAFE_MASTER_CODE_EN
  localparam bit MASTER_EN = 1'b1;
`else
  localparam bit MASTER_EN = 1'b0;
`endif

  localparam int ST_UNSET = 0, ST_LOCKED = 1, ST_SUCCESS = 2, ST_ERROR = 3,
                 ST_LOCKOUT = 4, ST_UNLOCKED = 5;

  typedef struct packed {
    logic [2:0]  st;
    logic        lk;
    logic [2:0]  cnt;
    logic [15:0] dig;
    logic [1:0]  fc;
  } snap_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] key = 12'd0;
  logic        lock;
  logic [2:0]  state_o;
  logic [2:0]  entry_cnt;
  logic [15:0] entry_digits;
  logic [1:0]  fail_cnt;

  int checks = 0;
  int errors = 0;

  snap_t exp_q[$];

  safe_lock_ctrl_param #(
    .CODE_LEN(CODE_LEN), .MSG_TICKS(MSG_TICKS), .MAX_FAILS(MAX_FAILS),
    .LOCKOUT_TICKS(LOCKOUT_TICKS), .MASTER_CODE(TB_MASTER)
  ) dut (
    .clk(clk), .rst(rst), .key(key), .lock(lock), .state_o(state_o),
    .entry_cnt(entry_cnt), .entry_digits(entry_digits), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: digits kept in queues, timed states as a remaining-cycle count
  int          m_state;
  int          m_entry[$];
  int          m_code[$];
  int          m_fail;
  int          m_rem;
  logic [11:0] m_prev;

  function automatic void model_reset();
    m_state = ST_UNSET;
    m_entry.delete();
    m_code.delete();
    m_fail  = 0;
    m_rem   = 0;
    m_prev  = 12'd0;
  endfunction

  function automatic bit entry_is_code();
    if (m_code.size() != m_entry.size()) return 1'b0;
    foreach (m_entry[i]) if (m_entry[i] != m_code[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit entry_is_master();
    logic [4*CODE_LEN-1:0] mc;
    mc = TB_MASTER;
    foreach (m_entry[i]) if (m_entry[i] != int'(mc[4*(CODE_LEN-1-i) +: 4])) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void evaluate();
    if (m_state != ST_LOCKED) begin
      m_code = m_entry;
      m_state = ST_LOCKED;
    end else if (entry_is_code() || (MASTER_EN && entry_is_master())) begin
      m_state = ST_SUCCESS;
      m_rem = MSG_TICKS;
      m_fail = 0;
    end else begin
      m_fail++;
      if (m_fail >= MAX_FAILS) begin
        m_state = ST_LOCKOUT;
        m_rem = LOCKOUT_TICKS;
      end else begin
        m_state = ST_ERROR;
        m_rem = MSG_TICKS;
      end
    end
    m_entry.delete();
  endfunction

  function automatic void model_edge(input logic [11:0] k);
    bit ev;
    ev = ($countones(k) == 1) && (m_prev == 12'd0);
    m_prev = k;
    if (m_state == ST_SUCCESS || m_state == ST_ERROR || m_state == ST_LOCKOUT) begin
      m_rem--;
      if (m_rem == 0) begin
        if (m_state == ST_SUCCESS) m_state = ST_UNLOCKED;
        else begin
          if (m_state == ST_LOCKOUT) m_fail = 0;
          m_state = ST_LOCKED;
        end
      end
    end else if (ev) begin
      if (k[10]) m_entry.delete();
      else if (k[9:0] != 10'd0) begin
        m_entry.push_back($clog2(k));
        if (m_entry.size() == CODE_LEN) evaluate();
      end
    end
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.st  = 3'(m_state);
    s.lk  = (m_state != ST_UNSET) && (m_state != ST_UNLOCKED);
    s.cnt = 3'(m_entry.size());
    s.dig = '1;
    foreach (m_entry[i]) s.dig[4*(CODE_LEN-1-i) +: 4] = 4'(m_entry[i]);
    s.fc  = 2'(m_fail);
    return s;
  endfunction

  // Monitor: one expected snapshot per clock, compared away from the active edge
  always @(negedge clk) begin
    snap_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{st: state_o, lk: lock, cnt: entry_cnt, dig: entry_digits, fc: fail_cnt};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL snapshot t=%0t: got st=%0d lock=%0b cnt=%0d dig=%h fails=%0d, need st=%0d lock=%0b cnt=%0d dig=%h fails=%0d",
                 $time, a.st, a.lk, a.cnt, a.dig, a.fc, e.st, e.lk, e.cnt, e.dig, e.fc);
      end
    end
  end

  task automatic step(input logic [11:0] k);
    key = k;
    @(posedge clk);
    model_edge(k);
    exp_q.push_back(model_snap());
    #1;
  endtask

  task automatic press(input logic [11:0] k, input int hold, input int gap);
    for (int i = 0; i < hold; i++) step(k);
    for (int i = 0; i < gap; i++) step(12'd0);
  endtask

  task automatic enter4(input int a, input int b, input int c, input int d);
    press(12'(1) << a, 2, 1);
    press(12'(1) << b, 2, 1);
    press(12'(1) << c, 2, 1);
    press(12'(1) << d, 2, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(12'd0);
  endtask

  // Asynchronous reset, checked immediately without waiting for a clock edge
  task automatic do_reset();
    @(negedge clk);
    #2;
    key = 12'd0;
    rst = 1'b1;
    #1;
    checks++;
    if (state_o !== 3'd0 || lock !== 1'b0 || entry_cnt !== 3'd0 ||
        entry_digits !== 16'hFFFF || fail_cnt !== 2'd0) begin
      errors++;
      $display("FAIL async_reset: got st=%0d lock=%0b cnt=%0d dig=%h fails=%0d, need st=0 lock=0 cnt=0 dig=ffff fails=0",
               state_o, lock, entry_cnt, entry_digits, fail_cnt);
    end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, need completion within time limit");
    $fatal(1);
  end

  initial begin
    model_reset();
    do_reset();

    enter4(1, 2, 3, 4);
    idle(2);
    enter4(9, 9, 9, 9);
    idle(12);
    enter4(1, 2, 3, 4);
    press(12'(1) << 5, 2, 1);
    idle(12);
    enter4(4, 3, 2, 1);
    enter4(4, 3, 2, 1);
    idle(12);
    enter4(1, 2, 3, 4);
    idle(12);
    for (int r = 0; r < 3; r++) begin
      enter4(5, 5, 5, 5);
      idle(12);
    end
    idle(45);
    enter4(4, 3, 2, 1);
    idle(12);
    enter4(1, 2, 3, 4);
    press(12'(1) << 1, 2, 1);
    press(12'(1) << 2, 2, 1);
    press(12'h400, 2, 1);
    enter4(1, 2, 3, 4);
    idle(12);
    enter4(1, 2, 3, 4);
    press(12'h006, 2, 1);
    press(12'h800, 2, 1);
    enter4(0, 0, 0, 0);
    idle(12);
    enter4(1, 2, 3, 4);
    idle(12);
    enter4(9, 9, 9, 8);
    idle(3);
    do_reset();

    // Randomized phase: digits, clears, multi-hot, holds, correct codes, idles, rare resets
    for (int n = 0; n < 600; n++) begin
      int act;
      act = $urandom_range(0, 19);
      if (act <= 9) begin
        press(12'(1) << $urandom_range(0, 9), $urandom_range(1, 3), $urandom_range(0, 2));
      end else if (act == 10) begin
        press(12'h400, $urandom_range(1, 2), $urandom_range(0, 1));
      end else if (act == 11) begin
        press(12'($urandom_range(1, 4095)), $urandom_range(1, 2), $urandom_range(0, 1));
      end else if (act <= 15) begin
        if (m_code.size() == CODE_LEN)
          enter4(m_code[0], m_code[1], m_code[2], m_code[3]);
        else
          enter4($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9));
      end else if (act <= 18) begin
        idle($urandom_range(1, 15));
      end else if ($urandom_range(0, 9) == 0) begin
        do_reset();
      end else begin
        press(12'(1) << $urandom_range(0, 9), $urandom_range(8, 20), 0);
      end
    end

    idle(2);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
